// File: rtl/moore_sched_pkg.sv
// Shared types and Moore detector table for the time-multiplexed scheduler.
// Detector encodings S0..S3 plus next-state and output helper functions.
package moore_sched_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } ms_state_t;

    function automatic ms_state_t MS_NEXT(input ms_state_t s, input logic a);
        ms_state_t n;
        case (s)
            S0:      n = a ? S0 : S2;
            S1:      n = a ? S0 : S2;
            S2:      n = a ? S2 : S3;
            S3:      n = a ? S1 : S3;
            default: n = S0;
        endcase
        return n;
    endfunction

    // Moore output depends only on the state reached, never on the input bit.
    function automatic logic MS_OUT(input ms_state_t s);
        return (s == S0) || (s == S3);
    endfunction

endpackage

// File: rtl/moore_next.sv
// Combinational detector engine shared by all channels; it sees only the
// context of whichever channel currently holds the grant.
module moore_next
    import moore_sched_pkg::*;
(
    input  logic [1:0] state_in,
    input  logic       a,
    output logic [1:0] state_nxt,
    output logic       z
);

    ms_state_t nxt;

    always_comb begin
        nxt       = MS_NEXT(ms_state_t'(state_in), a);
        state_nxt = nxt;
        z         = MS_OUT(nxt);
    end

endmodule

// File: rtl/moore_sched.sv
// Round-robin scheduler sharing one Moore detector among NCH bit-stream channels.
// Optional per-channel saturating hit counters are built when MSCHED_HITCNT_EN is defined.
module moore_sched
    import moore_sched_pkg::*;
#(
    parameter int NCH = 4
`ifdef MSCHED_HITCNT_EN
    ,
    parameter int HW  = 8
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          req,
    input  logic [NCH-1:0]          a_in,
    input  logic [NCH-1:0]          ch_clr,
    output logic [NCH-1:0]          ack,
    output logic                    z_valid,
    output logic                    z,
    output logic [$clog2(NCH)-1:0]  z_ch
`ifdef MSCHED_HITCNT_EN
    ,
    output logic [NCH*HW-1:0]       hit_cnt
`endif
);

    localparam int CW = $clog2(NCH);

    ms_state_t       ctx [NCH];
    logic [CW-1:0]   last;
    logic [NCH-1:0]  eligible;
    logic            grant_valid;
    logic [CW-1:0]   grant_id;
    logic [1:0]      eng_state;
    logic [1:0]      eng_next;
    logic            eng_z;

    assign eligible = req & ~ch_clr;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!grant_valid && eligible[(int'(last) + k) % NCH]) begin
                grant_valid = 1'b1;
                grant_id    = CW'((int'(last) + k) % NCH);
            end
        end
    end

    assign eng_state = ctx[grant_id];

    moore_next u_engine (
        .state_in  (eng_state),
        .a         (a_in[grant_id]),
        .state_nxt (eng_next),
        .z         (eng_z)
    );

    // A cleared channel is never eligible, so a clear and a write-back never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ctx[i] <= S0;
            end
            last    <= CW'(NCH - 1);
            ack     <= '0;
            z_valid <= 1'b0;
            z       <= 1'b0;
            z_ch    <= '0;
        end else begin
            ack     <= '0;
            z_valid <= 1'b0;
            z       <= 1'b0;
            z_ch    <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (ch_clr[i]) begin
                    ctx[i] <= S0;
                end
            end
            if (grant_valid) begin
                ctx[grant_id] <= ms_state_t'(eng_next);
                ack[grant_id] <= 1'b1;
                z_valid       <= 1'b1;
                z             <= eng_z;
                z_ch          <= grant_id;
                last          <= grant_id;
            end
        end
    end

`ifdef MSCHED_HITCNT_EN
    logic [HW-1:0] hits [NCH];

    // Counters stick at all-ones; a clear beats a simultaneous hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                hits[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_clr[i]) begin
                    hits[i] <= '0;
                end else if (grant_valid && grant_id == CW'(i) && eng_z && hits[i] != '1) begin
                    hits[i] <= hits[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            hit_cnt[i*HW +: HW] = hits[i];
        end
    end
`endif

endmodule

// File: tb/tb_moore_sched.sv
// Directed self-checking bench for moore_sched (NCH=4); hit counters are
// exercised with HW=2 when MSCHED_HITCNT_EN is defined.
module tb_moore_sched;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] a_in;
    logic [3:0] ch_clr;
    logic [3:0] ack;
    logic       z_valid;
    logic       z;
    logic [1:0] z_ch;
`ifdef MSCHED_HITCNT_EN
    logic [7:0] hit_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    moore_sched #(
        .NCH (4)
`ifdef MSCHED_HITCNT_EN
        ,
        .HW  (2)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a_in    (a_in),
        .ch_clr  (ch_clr),
        .ack     (ack),
        .z_valid (z_valid),
        .z       (z),
        .z_ch    (z_ch)
`ifdef MSCHED_HITCNT_EN
        ,
        .hit_cnt (hit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference of the detector table.
    function automatic logic [1:0] model_next(input logic [1:0] s, input logic a);
        case (s)
            2'd0:    return a ? 2'd0 : 2'd2;
            2'd1:    return a ? 2'd0 : 2'd2;
            2'd2:    return a ? 2'd2 : 2'd3;
            default: return a ? 2'd1 : 2'd3;
        endcase
    endfunction

    function automatic logic model_out(input logic [1:0] s);
        return (s == 2'd0) || (s == 2'd3);
    endfunction

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] a, input logic [3:0] c);
        req    = r;
        a_in   = a;
        ch_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] e_ack, input logic e_zv,
                               input logic e_z, input logic [1:0] e_zch);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {ack, z_valid, z, z_ch};
        exp = {e_ack, e_zv, e_z, e_zch};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed {ack,zv,z,zch}=%b expected=%b", tag, obs, exp);
        end
    endtask

`ifdef MSCHED_HITCNT_EN
    task automatic checkHits(input string tag, input logic [1:0] e_cnt);
        vectors++;
        assert (hit_cnt[1:0] === e_cnt) else begin
            miscompares++;
            $error("[TB] FAIL %s observed hit_cnt0=%0d expected=%0d", tag, hit_cnt[1:0], e_cnt);
        end
    endtask
`endif

    task automatic doReset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] m2, m3;
        int         p2, p3, exp_ch;
        bit         seq2 [6];
        bit         seq3 [6];
        logic       abit;
        logic       ez;

        seq2 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        seq3 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        reset  = 1'b1;
        req    = '0;
        a_in   = '0;
        ch_clr = '0;
        #12;
        checkOutput("reset", 4'b0000, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;

        // Single requester on channel 0: a=0,0,1,1 walks S2,S3,S1,S0.
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("ch0_b0", 4'b0001, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("ch0_b1", 4'b0001, 1'b1, 1'b1, 2'd0);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkOutput("ch0_b2", 4'b0001, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkOutput("ch0_b3", 4'b0001, 1'b1, 1'b1, 2'd0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("idle1", 4'b0000, 1'b0, 1'b0, 2'd0);

        // All four requesting, a_in fixed at 1010: strict rotation from channel 0.
        doReset();
        applyStimulus(4'b1111, 4'b1010, 4'b0000);
        checkOutput("rr_c1", 4'b0001, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 4'b1010, 4'b0000);
        checkOutput("rr_c2", 4'b0010, 1'b1, 1'b1, 2'd1);
        applyStimulus(4'b1111, 4'b1010, 4'b0000);
        checkOutput("rr_c3", 4'b0100, 1'b1, 1'b0, 2'd2);
        applyStimulus(4'b1111, 4'b1010, 4'b0000);
        checkOutput("rr_c4", 4'b1000, 1'b1, 1'b1, 2'd3);
        applyStimulus(4'b1111, 4'b1010, 4'b0000);
        checkOutput("rr_c5", 4'b0001, 1'b1, 1'b1, 2'd0);
        applyStimulus(4'b1111, 4'b1010, 4'b0000);
        checkOutput("rr_c6", 4'b0010, 1'b1, 1'b1, 2'd1);
        applyStimulus(4'b1111, 4'b1010, 4'b0000);
        checkOutput("rr_c7", 4'b0100, 1'b1, 1'b1, 2'd2);
        applyStimulus(4'b1111, 4'b1010, 4'b0000);
        checkOutput("rr_c8", 4'b1000, 1'b1, 1'b1, 2'd3);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("idle2", 4'b0000, 1'b0, 1'b0, 2'd0);

        // Drive channel 1 to S3, clear it, then clear alongside a grant to channel 0.
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        checkOutput("ch1_b0", 4'b0010, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        checkOutput("ch1_b1", 4'b0010, 1'b1, 1'b1, 2'd1);
        applyStimulus(4'b0010, 4'b0000, 4'b0010);
        checkOutput("clr_noack", 4'b0000, 1'b0, 1'b0, 2'd0);
        applyStimulus(4'b0011, 4'b0001, 4'b0010);
        checkOutput("clr_plus_grant", 4'b0001, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b0010, 4'b0010, 4'b0000);
        checkOutput("ch1_after_clr", 4'b0010, 1'b1, 1'b1, 2'd1);

        // Mid-cycle reset clears outputs at once and restarts from channel 0.
        applyStimulus(4'b1111, 4'b0000, 4'b0000);
        checkOutput("pre_reset", 4'b0100, 1'b1, 1'b1, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 4'b0000, 1'b0, 1'b0, 2'd0);
        #1;
        reset = 1'b0;
        applyStimulus(4'b1111, 4'b0100, 4'b0000);
        checkOutput("post_rst_c0", 4'b0001, 1'b1, 1'b0, 2'd0);
        applyStimulus(4'b1111, 4'b0100, 4'b0000);
        checkOutput("post_rst_c1", 4'b0010, 1'b1, 1'b0, 2'd1);
        applyStimulus(4'b1111, 4'b0100, 4'b0000);
        checkOutput("post_rst_c2", 4'b0100, 1'b1, 1'b1, 2'd2);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("idle3", 4'b0000, 1'b0, 1'b0, 2'd0);

        // Channels 2 and 3 interleaved, checked against a standalone model each.
        m2 = 2'd0;
        m3 = 2'd0;
        p2 = 0;
        p3 = 0;
        exp_ch = 3;
        for (int it = 0; it < 12; it++) begin
            applyStimulus(4'b1100,
                          {seq3[p3 < 6 ? p3 : 5], seq2[p2 < 6 ? p2 : 5], 2'b00},
                          4'b0000);
            if (exp_ch == 3) begin
                abit = seq3[p3];
                m3   = model_next(m3, abit);
                ez   = model_out(m3);
                p3++;
            end else begin
                abit = seq2[p2];
                m2   = model_next(m2, abit);
                ez   = model_out(m2);
                p2++;
            end
            checkOutput($sformatf("ilv_%0d", it), 4'(1 << exp_ch), 1'b1, ez, 2'(exp_ch));
            exp_ch = (exp_ch == 3) ? 2 : 3;
        end

`ifdef MSCHED_HITCNT_EN
        // Channel 0 stays in S0 with a=1, so every grant is a hit; HW=2 saturates at 3.
        doReset();
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkHits("hit_1", 2'd1);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkHits("hit_2", 2'd2);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkHits("hit_3", 2'd3);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkHits("hit_sat4", 2'd3);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkHits("hit_sat5", 2'd3);
        applyStimulus(4'b0000, 4'b0001, 4'b0001);
        checkHits("hit_clr", 2'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
